// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding, BCD digit widths and counter sizing helper.
package alarm_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RINGING = 2'b01,
    SNOOZE  = 2'b10
  } state_t;
  localparam int MIN_U_W = 4;
  localparam int MIN_T_W = 3;
  localparam int HR_U_W  = 4;
  localparam int HR_T_W  = 2;
  function automatic int cnt_w(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction
endpackage

// File: rtl/alarm_tick_counter.sv
// alarm_tick_counter: modulo counter with synchronous clear, count enable and terminal-count flag.
module alarm_tick_counter
  import alarm_pkg::*;
#(
  parameter int MODULUS = 60
) (
  input  logic clk_out,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = cnt_w(MODULUS);
  logic [W-1:0] cnt;
  assign tc = (cnt == W'(MODULUS - 1));
  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/alarm_ringer.sv
// alarm_ringer: rings on a rising alarm-time match, with snooze, stop and auto-stop after RING_SECONDS.
module alarm_ringer
  import alarm_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5
) (
  input  logic               clk_out,
  input  logic               reset,
  input  logic               sec_tick,
  input  logic               alarm_en,
  input  logic               btn_stop,
  input  logic               btn_snooze,
  input  logic [MIN_U_W-1:0] time_minutes_units,
  input  logic [MIN_T_W-1:0] time_minutes_tens,
  input  logic [HR_U_W-1:0]  time_hours_units,
  input  logic [HR_T_W-1:0]  time_hours_tens,
  input  logic [MIN_U_W-1:0] alarm_minutes_units,
  input  logic [MIN_T_W-1:0] alarm_minutes_tens,
  input  logic [HR_U_W-1:0]  alarm_hours_units,
  input  logic [HR_T_W-1:0]  alarm_hours_tens,
  output logic               buzzer,
  output logic               ringing,
  output logic               snoozing,
  output logic [1:0]         state
);
  localparam int SNOOZE_TICKS = SNOOZE_MINUTES * 60;
  state_t cur, nxt;
  logic match, match_q, trigger, beep, beep_nxt;
  logic ring_clr, ring_en, ring_tc, snz_clr, snz_en, snz_tc;
  assign match = alarm_en
              && time_minutes_units == alarm_minutes_units
              && time_minutes_tens  == alarm_minutes_tens
              && time_hours_units   == alarm_hours_units
              && time_hours_tens    == alarm_hours_tens;
  assign trigger = match && !match_q;
  assign state = cur;
  alarm_tick_counter #(.MODULUS(RING_SECONDS)) u_ring (
    .clk_out(clk_out), .reset(reset), .clr(ring_clr), .en(ring_en), .tc(ring_tc)
  );
  alarm_tick_counter #(.MODULUS(SNOOZE_TICKS)) u_snooze (
    .clk_out(clk_out), .reset(reset), .clr(snz_clr), .en(snz_en), .tc(snz_tc)
  );
  // Only events that matter in the current state compete; priority is stop-first.
  always_comb begin
    nxt      = cur;
    beep_nxt = beep;
    ring_clr = 1'b0;
    ring_en  = 1'b0;
    snz_clr  = 1'b0;
    snz_en   = 1'b0;
    case (cur)
      IDLE: if (trigger) begin
        nxt      = RINGING;
        ring_clr = 1'b1;
        beep_nxt = 1'b1;
      end
      RINGING: if (!alarm_en || btn_stop) nxt = IDLE;
      else if (btn_snooze) begin
        nxt     = SNOOZE;
        snz_clr = 1'b1;
      end else if (sec_tick) begin
        ring_en  = 1'b1;
        beep_nxt = !beep;
        nxt      = ring_tc ? IDLE : RINGING;
      end
      SNOOZE: if (!alarm_en || btn_stop) nxt = IDLE;
      else if (sec_tick) begin
        snz_en = 1'b1;
        if (snz_tc) begin
          nxt      = RINGING;
          ring_clr = 1'b1;
          beep_nxt = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      cur      <= IDLE;
      match_q  <= 1'b1;
      beep     <= 1'b0;
      buzzer   <= 1'b0;
      ringing  <= 1'b0;
      snoozing <= 1'b0;
    end else begin
      cur      <= nxt;
      match_q  <= match;
      beep     <= beep_nxt;
      buzzer   <= beep_nxt && (nxt == RINGING);
      ringing  <= (nxt == RINGING);
      snoozing <= (nxt == SNOOZE);
    end
  end
endmodule

// File: tb/tb_alarm_ringer.sv
// tb_alarm_ringer: directed and randomized checks of alarm_ringer against an elapsed-tick model.
module tb_alarm_ringer;
  import alarm_pkg::*;
  localparam int RS = 60;
  localparam int ST = 5 * 60;
  logic clk_out = 1'b0;
  logic reset = 1'b0;
  logic sec_tick = 1'b0, alarm_en = 1'b1, btn_stop = 1'b0, btn_snooze = 1'b0;
  logic [MIN_U_W-1:0] tmu, amu;
  logic [MIN_T_W-1:0] tmt, amt;
  logic [HR_U_W-1:0]  thu, ahu;
  logic [HR_T_W-1:0]  tht, aht;
  logic buzzer, ringing, snoozing;
  logic [1:0] state;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    int mode;
    int rt;
    int st;
    bit pm;
  } mdl_t;
  mdl_t m = '{0, 0, 0, 1'b1};
  alarm_ringer dut (
    .clk_out(clk_out), .reset(reset), .sec_tick(sec_tick), .alarm_en(alarm_en),
    .btn_stop(btn_stop), .btn_snooze(btn_snooze),
    .time_minutes_units(tmu), .time_minutes_tens(tmt),
    .time_hours_units(thu), .time_hours_tens(tht),
    .alarm_minutes_units(amu), .alarm_minutes_tens(amt),
    .alarm_hours_units(ahu), .alarm_hours_tens(aht),
    .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing), .state(state)
  );
  always #5 clk_out = ~clk_out;
  // mode: 0 idle, 1 ringing (rt ticks elapsed), 2 snoozing (st ticks elapsed)
  function automatic mdl_t model_next(input mdl_t c);
    mdl_t n = c;
    bit mt = alarm_en && tmu == amu && tmt == amt && thu == ahu && tht == aht;
    n.pm = mt;
    if (c.mode == 0) begin
      if (mt && !c.pm) begin
        n.mode = 1;
        n.rt = 0;
      end
    end else if (!alarm_en || btn_stop) n.mode = 0;
    else if (c.mode == 1) begin
      if (btn_snooze) begin
        n.mode = 2;
        n.st = 0;
      end else if (sec_tick) begin
        n.rt = c.rt + 1;
        if (n.rt == RS) n.mode = 0;
      end
    end else if (sec_tick) begin
      n.st = c.st + 1;
      if (n.st == ST) begin
        n.mode = 1;
        n.rt = 0;
      end
    end
    return n;
  endfunction
  always @(posedge clk_out or negedge reset) begin
    if (!reset) m <= '{0, 0, 0, 1'b1};
    else m <= model_next(m);
  end
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  always @(negedge clk_out) begin
    chk("model_ringing", ringing, int'(m.mode == 1));
    chk("model_snoozing", snoozing, int'(m.mode == 2));
    chk("model_state", state, m.mode);
    chk("model_buzzer", buzzer, int'(m.mode == 1 && m.rt % 2 == 0));
  end
  task automatic set_time(input int h, input int mi);
    tht = HR_T_W'(h / 10);
    thu = HR_U_W'(h % 10);
    tmt = MIN_T_W'(mi / 10);
    tmu = MIN_U_W'(mi % 10);
  endtask
  task automatic set_alarm(input int h, input int mi);
    aht = HR_T_W'(h / 10);
    ahu = HR_U_W'(h % 10);
    amt = MIN_T_W'(mi / 10);
    amu = MIN_U_W'(mi % 10);
  endtask
  task automatic step(input bit tk, input bit sp, input bit sz);
    sec_tick = tk;
    btn_stop = sp;
    btn_snooze = sz;
    @(posedge clk_out);
    #1;
    sec_tick = 1'b0;
    btn_stop = 1'b0;
    btn_snooze = 1'b0;
  endtask
  task automatic tick_n(input int n);
    repeat (n) begin
      step(1, 0, 0);
      step(0, 0, 0);
    end
  endtask
  task automatic retrigger();
    set_time(7, 31);
    step(0, 0, 0);
    set_time(7, 30);
    step(0, 0, 0);
  endtask
  initial begin
    set_alarm(7, 30);
    set_time(7, 30);
    #23;
    chk("reset_buzzer", buzzer, 0);
    chk("reset_ringing", ringing, 0);
    chk("reset_snoozing", snoozing, 0);
    chk("reset_state", state, 0);
    @(posedge clk_out);
    #1 reset = 1'b1;
    repeat (3) step(0, 0, 0);
    chk("match_at_release_idle", state, 0);
    retrigger();
    chk("trigger_ringing", ringing, 1);
    chk("trigger_buzzer", buzzer, 1);
    step(1, 0, 0);
    chk("tick1_buzzer", buzzer, 0);
    step(1, 0, 0);
    chk("tick2_buzzer", buzzer, 1);
    tick_n(57);
    chk("tick59_ringing", ringing, 1);
    tick_n(1);
    chk("tick60_idle", state, 0);
    repeat (5) step(0, 0, 0);
    chk("held_match_no_rering", ringing, 0);
    retrigger();
    step(0, 0, 1);
    chk("snooze_flag", snoozing, 1);
    chk("snooze_buzzer", buzzer, 0);
    chk("snooze_state", state, 2);
    tick_n(299);
    chk("snooze299_still", snoozing, 1);
    tick_n(1);
    chk("snooze_end_ringing", ringing, 1);
    chk("snooze_end_buzzer", buzzer, 1);
    step(0, 1, 1);
    chk("stop_beats_snooze", state, 0);
    retrigger();
    step(0, 0, 1);
    alarm_en = 1'b0;
    step(0, 0, 0);
    chk("en_drop_in_snooze", state, 0);
    alarm_en = 1'b1;
    step(0, 0, 0);
    chk("en_rise_rings", ringing, 1);
    reset = 1'b0;
    #1;
    chk("async_rst_buzzer", buzzer, 0);
    chk("async_rst_ringing", ringing, 0);
    chk("async_rst_state", state, 0);
    @(posedge clk_out);
    #1 reset = 1'b1;
    repeat (4000) begin
      sec_tick = ($urandom % 3) == 0;
      btn_stop = ($urandom % 400) == 0;
      btn_snooze = ($urandom % 60) == 0;
      if (alarm_en ? ($urandom % 600) == 0 : ($urandom % 8) == 0) alarm_en = ~alarm_en;
      if (($urandom % 25) == 0) set_time(7, 29 + int'($urandom % 3));
      if (($urandom % 400) == 0) set_alarm(7, 30 + int'($urandom % 2));
      reset = ($urandom % 900) != 0;
      @(posedge clk_out);
      #1;
    end
    reset = 1'b1;
    sec_tick = 1'b0;
    btn_stop = 1'b0;
    btn_snooze = 1'b0;
    @(posedge clk_out);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alarm_ringer.md
ALARM_RINGER -- requirements
Module: alarm_ringer

Interface
REQ-001 The block SHALL have parameter RING_SECONDS, default 60, giving the number of sec_tick pulses before an unanswered alarm auto-stops.
REQ-002 The block SHALL have parameter SNOOZE_MINUTES, default 5, giving the snooze length in minutes, counted as SNOOZE_MINUTES*60 sec_tick pulses.
REQ-003 clk_out  input  1  Single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  Asynchronous, active-low reset.
REQ-005 sec_tick  input  1  One-clk_out-cycle pulse, once per second.
REQ-006 alarm_en  input  1  Alarm armed (level).
REQ-007 btn_stop, btn_snooze  input  1 each  Debounced single-cycle button pulses.
REQ-008 time_minutes_units 4, time_minutes_tens 3, time_hours_units 4, time_hours_tens 2  input  Current time BCD digits.
REQ-009 alarm_minutes_units 4, alarm_minutes_tens 3, alarm_hours_units 4, alarm_hours_tens 2  input  Alarm-set BCD digits from the alarm counter.
REQ-010 buzzer  output  1  Beep drive: 1 s on / 1 s off pattern while ringing.
REQ-011 ringing, snoozing  output  1 each  State flags.
REQ-012 state  output  2  Encoded FSM state.

Function
REQ-013 match SHALL be combinational: alarm_en AND all four digit pairs equal.
REQ-014 match_q SHALL register match each cycle; trigger = match AND NOT match_q (rising edge only), so a held match rings at most once.
REQ-015 FSM states SHALL be IDLE=2'b00, RINGING=2'b01, SNOOZE=2'b10; 2'b11 SHALL return to IDLE on the next edge.
REQ-016 Event priority within a cycle SHALL be: alarm_en low > btn_stop > btn_snooze > sec_tick > trigger.
REQ-017 IDLE: trigger -> RINGING, ring_cnt cleared, beep phase set to 1.
REQ-018 RINGING: alarm_en low or btn_stop -> IDLE; btn_snooze -> SNOOZE with snooze_cnt cleared.
REQ-019 RINGING: each sec_tick SHALL increment ring_cnt and toggle the beep phase; sec_tick with ring_cnt == RING_SECONDS-1 -> IDLE.
REQ-020 SNOOZE: alarm_en low or btn_stop -> IDLE; btn_snooze and trigger ignored.
REQ-021 SNOOZE: each sec_tick SHALL increment snooze_cnt; sec_tick with snooze_cnt == SNOOZE_MINUTES*60-1 -> RINGING, ring_cnt cleared, beep phase set to 1.
REQ-022 All outputs SHALL be registered; ringing, snoozing and state reflect the FSM state; buzzer = beep phase AND (state == RINGING).
REQ-023 Latency: digits matching at edge N SHALL give ringing = 1 and buzzer = 1 after edge N+1.
REQ-024 ring_cnt width SHALL be $clog2(RING_SECONDS), snooze_cnt width $clog2(SNOOZE_MINUTES*60); neither counter wraps (the state exits at terminal count).
REQ-025 Alarm digits changing while RINGING or SNOOZE SHALL NOT affect the current ring or snooze sequence.

Reset
REQ-026 reset low SHALL force state IDLE, ring_cnt 0, snooze_cnt 0, beep phase 0, buzzer 0, ringing 0, snoozing 0, state 2'b00, all asynchronously.
REQ-027 match_q SHALL reset to 1, so a match already present at reset release does not ring.
REQ-028 Reset asserted mid-RINGING or mid-SNOOZE SHALL abort the sequence without a pending re-ring.

Structure
REQ-029 Shared package alarm_pkg SHALL hold the state encoding constants and the BCD digit widths (4/3/4/2).
REQ-030 One sub-module alarm_tick_counter SHALL implement a parameterised modulo counter with synchronous clear, count enable and a terminal-count flag; it SHALL be instantiated twice (ring and snooze).

Verification
REQ-031 Time and alarm both 07:30 with match rising, alarm_en=1 -> ringing=1, buzzer=1 one cycle later; buzzer toggles on every sec_tick.
REQ-032 Ringing with no button, 60 sec_ticks -> IDLE after the 60th tick; match still held -> no re-ring.
REQ-033 btn_snooze while ringing -> snoozing=1, buzzer=0; 300 sec_ticks later -> ringing=1, buzzer=1.
REQ-034 btn_stop and btn_snooze in the same cycle while ringing -> IDLE (stop wins).
REQ-035 Reset released with digits already matching -> stays IDLE; then change time to 07:31 and back to 07:30 -> rings.
REQ-036 alarm_en dropped during SNOOZE -> IDLE next edge; reset pulse mid-RINGING -> all outputs 0 immediately.
